wb_master_bridge: RTL
=====================

Name: wb_master_bridge

Overview:
- Wishbone classic initiator: turns single commands from a valid/ready command port into one Wishbone B4 classic read or write cycle.
- Returns the result on a valid/ready response port.
- Sits in the user project area and drives the slave port of the golden macro, so on-chip logic (LA- or IO-driven test sequencers) can exercise that slave without the management core.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles to wait for ack before aborting. Used only with WB_MASTER_TIMEOUT_EN. Legal range is 1..65535.
- TXN_CNT_W, 16: width of the completed-transaction counter.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  asynchronous active-high reset
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  command accepted when valid and ready are both high
- cmd_we_i  in  1  1 = write, 0 = read
- cmd_adr_i  in  32  byte address
- cmd_dat_i  in  32  write data
- cmd_sel_i  in  4  byte selects
- rsp_valid_o  out  1  response present
- rsp_ready_i  in  1  response consumed
- rsp_dat_o  out  32  read data (0 for writes)
- rsp_err_o  out  1  transaction timed out
- wbm_cyc_o  out  1  Wishbone cycle
- wbm_stb_o  out  1  Wishbone strobe
- wbm_we_o  out  1  Wishbone write enable
- wbm_adr_o  out  32  Wishbone address
- wbm_dat_o  out  32  Wishbone write data
- wbm_sel_o  out  4  Wishbone byte selects
- wbm_dat_i  in  32  Wishbone read data
- wbm_ack_i  in  1  Wishbone acknowledge
- busy_o  out  1  FSM not IDLE
- txn_count_o  out  TXN_CNT_W  completed transactions, wraps

Behaviour:
- Reset values: all outputs registered and 0. The exception is cmd_ready_o, which is combinational (state == IDLE) and therefore 1 in reset.
- FSM has three states: IDLE, BUS, RESP.
- IDLE:
  - cmd_ready_o = 1.
  - On cmd_valid_i, latch we/adr/dat/sel into wbm_* registers, set cyc = stb = 1, move to BUS.
  - Cycle/strobe are first visible the cycle after acceptance.
- BUS:
  - cmd_ready_o = 0. cyc, stb, adr, dat, sel and we are held stable.
  - When wbm_ack_i is sampled high: clear cyc/stb at that edge, capture rsp_dat_o = wbm_dat_i for a read or 0 for a write, set rsp_err_o = 0 and rsp_valid_o = 1, increment txn_count_o, move to RESP.
  - Minimum latency with a zero-wait slave: accept at edge 0, ack sampled at edge 1, rsp_valid_o high after edge 1.
- RESP:
  - rsp_valid_o, rsp_dat_o and rsp_err_o are held until rsp_ready_i is high.
  - At that edge: clear rsp_valid_o and return to IDLE.
  - A new command cannot be accepted in the same cycle; the earliest acceptance is the following cycle.
- wbm_ack_i outside BUS is ignored: no state change, no counter change.
- wbm_dat_o, wbm_adr_o and wbm_sel_o keep their last values after a cycle ends. They change only when a command is accepted.
- txn_count_o wraps from all-ones to 0. Timed-out transactions also count.
- Reset mid-operation: wb_rst_i forces IDLE and drops cyc/stb/rsp_valid asynchronously. The in-flight command and response are discarded; no response is produced.
- cmd_* inputs are don't-care when cmd_valid_i = 0 or cmd_ready_o = 0.

Optional Feature:
- Macro: WB_MASTER_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to BUS and increments each BUS cycle without ack.
  - When it reaches TIMEOUT_CYCLES with no ack, drop cyc/stb, set rsp_dat_o = 32'hDEAD_BEEF and rsp_err_o = 1, move to RESP.
  - An ack arriving in the same cycle as expiry wins: normal completion, err = 0.
- When undefined: no counter exists, BUS waits indefinitely, and rsp_err_o is tied to 0.

Decomposition:
- Package wb_master_pkg holds:
  - the state enum (IDLE, BUS, RESP);
  - constants WB_AW = 32, WB_DW = 32, WB_SELW = 4;
  - WB_ERR_DATA = 32'hDEAD_BEEF.
- No sub-module is needed. The FSM, datapath registers and timeout counter live in the single module.

Test Plan:
- Write adr 0x3000_0004, dat 0xA5A5_1234, sel 0xF, slave acks after 3 wait cycles -> wbm_* match the command, cyc/stb high for exactly 4 cycles, response dat 0, err 0, txn_count_o = 1.
- Read with a zero-wait slave returning 0x1357_9BDF -> rsp_valid_o high one edge after the ack, rsp_dat_o = 0x1357_9BDF, cmd_ready_o low from acceptance until return to IDLE.
- Response backpressure: rsp_ready_i low for 5 cycles -> rsp_valid_o and rsp_dat_o stable, cmd_valid_i ignored, busy_o = 1 throughout.
- Spurious ack pulse in IDLE and in RESP -> no state change, txn_count_o unchanged.
- With WB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES = 8, no ack -> cyc drops after 8 BUS cycles, rsp_err_o = 1, rsp_dat_o = 0xDEAD_BEEF. A second run with the ack on the expiry cycle -> err = 0.
- Assert wb_rst_i during BUS -> cyc/stb/rsp_valid_o low immediately, IDLE after release, the next command completes normally, and txn_count_o counts from 0.

Source files
------------

// File: rtl/wb_master_pkg.sv
// Shared types and constants for the Wishbone classic initiator bridge.
package wb_master_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WB_AW   = 32;
  localparam int WB_DW   = 32;
  localparam int WB_SELW = 4;

  localparam logic [WB_DW-1:0] WB_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/wb_master_bridge.sv
// Valid/ready command port to single Wishbone B4 classic read/write cycles.
// Optional ack timeout enabled by defining WB_MASTER_TIMEOUT_EN.
module wb_master_bridge
  import wb_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TXN_CNT_W      = 16
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_we_i,
  input  logic [WB_AW-1:0]     cmd_adr_i,
  input  logic [WB_DW-1:0]     cmd_dat_i,
  input  logic [WB_SELW-1:0]   cmd_sel_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [WB_DW-1:0]     rsp_dat_o,
  output logic                 rsp_err_o,
  output logic                 wbm_cyc_o,
  output logic                 wbm_stb_o,
  output logic                 wbm_we_o,
  output logic [WB_AW-1:0]     wbm_adr_o,
  output logic [WB_DW-1:0]     wbm_dat_o,
  output logic [WB_SELW-1:0]   wbm_sel_o,
  input  logic [WB_DW-1:0]     wbm_dat_i,
  input  logic                 wbm_ack_i,
  output logic                 busy_o,
  output logic [TXN_CNT_W-1:0] txn_count_o
);

  generate
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("wb_master_bridge: TIMEOUT_CYCLES must be in 1..65535");
    end
  endgenerate

  state_t state;

  assign cmd_ready_o = (state == IDLE);
  assign busy_o      = (state != IDLE);

`ifdef WB_MASTER_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt;
`else
  assign rsp_err_o = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
      wbm_sel_o   <= '0;
      rsp_valid_o <= 1'b0;
      rsp_dat_o   <= '0;
      txn_count_o <= '0;
`ifdef WB_MASTER_TIMEOUT_EN
      rsp_err_o   <= 1'b0;
      tmo_cnt     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            wbm_we_o  <= cmd_we_i;
            wbm_adr_o <= cmd_adr_i;
            wbm_dat_o <= cmd_dat_i;
            wbm_sel_o <= cmd_sel_i;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
`ifdef WB_MASTER_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
            state     <= BUS;
          end
        end

        BUS: begin
          // Ack is checked first so an ack on the expiry cycle completes normally.
          if (wbm_ack_i) begin
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            rsp_dat_o   <= wbm_we_o ? '0 : wbm_dat_i;
            rsp_valid_o <= 1'b1;
            txn_count_o <= txn_count_o + 1'b1;
`ifdef WB_MASTER_TIMEOUT_EN
            rsp_err_o   <= 1'b0;
`endif
            state       <= RESP;
          end
`ifdef WB_MASTER_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            rsp_dat_o   <= WB_ERR_DATA;
            rsp_err_o   <= 1'b1;
            rsp_valid_o <= 1'b1;
            txn_count_o <= txn_count_o + 1'b1;
            state       <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
`endif
        end

        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
